// File: rtl/cache_perf_pkg.sv
// Shared types, readout selector codes and the saturating increment used by
// the cache performance monitor.
package cache_perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WB    = 2'd2,
      ST_DRAIN = 2'd3
   } burst_state_e;

   localparam int NUM_CNT = 7;

   // Positions of the live/shadow counters inside a channel's counter bank.
   localparam int IDX_ACC   = 0;
   localparam int IDX_RD    = 1;
   localparam int IDX_WR    = 2;
   localparam int IDX_MISS  = 3;
   localparam int IDX_WB    = 4;
   localparam int IDX_RBEAT = 5;
   localparam int IDX_WBEAT = 6;

   localparam logic [3:0] SEL_ACC       = 4'd0;
   localparam logic [3:0] SEL_RD        = 4'd1;
   localparam logic [3:0] SEL_WR        = 4'd2;
   localparam logic [3:0] SEL_MISS      = 4'd3;
   localparam logic [3:0] SEL_WB        = 4'd4;
   localparam logic [3:0] SEL_RBEAT     = 4'd5;
   localparam logic [3:0] SEL_WBEAT     = 4'd6;
   localparam logic [3:0] SEL_HITS      = 4'd7;
   localparam logic [3:0] SEL_BUS_BYTES = 4'd8;
   localparam logic [3:0] SEL_STATUS    = 4'd9;

   // Callers widen their counter to 64 bits and truncate the result back.
   function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                           input logic [63:0] max_val);
      return (val == max_val) ? val : val + 64'd1;
   endfunction

endpackage

// File: rtl/cache_perf_chan.sv
// One monitored cache channel: request edge detection, burst FSM with
// watchdog, seven saturating live counters and their snapshot shadows.
module cache_perf_chan
   import cache_perf_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 20000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req,
   input  logic                            we,
   input  logic                            oe,
   input  logic                            mem_req,
   input  logic                            mem_wr,
   input  logic                            mem_rvalid,
   input  logic                            mem_ready,
   input  logic                            cnt_en,
   input  logic                            clr,
   input  logic                            snap,
   output logic [NUM_CNT-1:0][CNT_W-1:0]   shadow,
   output logic [1:0]                      state,
   output logic                            err
);

   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic                           req_q, req_d;
   logic                           mem_req_q, mem_req_d;
   burst_state_e                   state_q, state_d;
   logic [TMR_W-1:0]               timer_q, timer_d;
   logic                           err_q, err_d;
   logic [NUM_CNT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CNT-1:0][CNT_W-1:0]  shadow_q, shadow_d;

   logic                           access;
   logic                           burst_start;
   logic                           timeout;
   logic [NUM_CNT-1:0]             inc;

   always_comb begin
      req_d       = req;
      mem_req_d   = mem_req;
      state_d     = state_q;
      err_d       = err_q;
      timer_d     = '0;
      timeout     = 1'b0;
      access      = req & ~req_q;
      burst_start = mem_req & ~mem_req_q;

      inc            = '0;
      inc[IDX_ACC]   = access;
      inc[IDX_RD]    = access & oe;
      inc[IDX_WR]    = access & we;
      inc[IDX_RBEAT] = mem_rvalid;
      inc[IDX_WBEAT] = mem_ready;

      if (state_q != ST_IDLE) begin
         timer_d = timer_q + 1'b1;
         timeout = (timer_q == TMR_LAST);
      end

      // A stuck burst is abandoned uncounted, even if its first beat lands now.
      if (timeout) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (burst_start) state_d = mem_wr ? ST_WB : ST_LOAD;
            end
            ST_LOAD: begin
               inc[IDX_MISS] = mem_rvalid;
               if (!mem_req)        state_d = ST_IDLE;
               else if (mem_rvalid) state_d = ST_DRAIN;
            end
            ST_WB: begin
               inc[IDX_WB] = mem_ready;
               if (!mem_req)       state_d = ST_IDLE;
               else if (mem_ready) state_d = ST_DRAIN;
            end
            default: begin
               if (!mem_req) state_d = ST_IDLE;
            end
         endcase
      end

      if (clr) err_d = 1'b0;

      for (int i = 0; i < NUM_CNT; i++) begin
         if (clr)
            cnt_d[i] = '0;
         else if (cnt_en && inc[i])
            cnt_d[i] = CNT_W'(sat_inc(64'(cnt_q[i]), 64'(CNT_MAX)));
         else
            cnt_d[i] = cnt_q[i];
         shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
      end
   end

   // mem_req_q resets high so a burst already open at reset never looks like a new edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q     <= 1'b0;
         mem_req_q <= 1'b1;
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         shadow_q  <= '0;
      end else begin
         req_q     <= req_d;
         mem_req_q <= mem_req_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
      end
   end

   assign shadow = shadow_q;
   assign state  = state_q;
   assign err    = err_q;

endmodule

// File: rtl/cache_perf_mon.sv
// Multi-channel L1 cache performance monitor: per-channel counter blocks plus a
// registered readout port serving snapshot values and live status.
module cache_perf_mon
   import cache_perf_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int CNT_W      = 32,
   parameter int BEAT_BYTES = 8,
   parameter int TIMEOUT    = 20000,
   parameter int RD_W       = CNT_W + $clog2(BEAT_BYTES) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CHANNELS-1:0]  req,
   input  logic [CHANNELS-1:0]  we,
   input  logic [CHANNELS-1:0]  oe,
   input  logic [CHANNELS-1:0]  mem_req,
   input  logic [CHANNELS-1:0]  mem_wr,
   input  logic [CHANNELS-1:0]  mem_rvalid,
   input  logic [CHANNELS-1:0]  mem_ready,
   input  logic                 cnt_en,
   input  logic                 clr,
   input  logic                 snap,
   input  logic                 rd_en,
   input  logic [2:0]           rd_ch,
   input  logic [3:0]           rd_sel,
   output logic [RD_W-1:0]      rd_data,
   output logic                 rd_valid,
   output logic [CHANNELS-1:0]  err
);

   localparam int BEAT_SH = $clog2(BEAT_BYTES);

   logic [CHANNELS-1:0][NUM_CNT-1:0][CNT_W-1:0] shadow_all;
   logic [CHANNELS-1:0][1:0]                    state_all;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         cache_perf_chan #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
         ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .req        (req[gi]),
            .we         (we[gi]),
            .oe         (oe[gi]),
            .mem_req    (mem_req[gi]),
            .mem_wr     (mem_wr[gi]),
            .mem_rvalid (mem_rvalid[gi]),
            .mem_ready  (mem_ready[gi]),
            .cnt_en     (cnt_en),
            .clr        (clr),
            .snap       (snap),
            .shadow     (shadow_all[gi]),
            .state      (state_all[gi]),
            .err        (err[gi])
         );
      end
   endgenerate

   logic [NUM_CNT-1:0][CNT_W-1:0] sel_shadow;
   logic [1:0]                    sel_state;
   logic                          sel_err;
   logic                          ch_ok;
   logic [CNT_W-1:0]              hits;
   logic [RD_W-1:0]               bus_bytes;
   logic [RD_W-1:0]               rd_value;
   logic [RD_W-1:0]               rd_data_q, rd_data_d;
   logic                          rd_valid_q, rd_valid_d;

   always_comb begin
      sel_shadow = '0;
      sel_state  = '0;
      sel_err    = 1'b0;
      ch_ok      = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_ch == 3'(c)) begin
            ch_ok      = 1'b1;
            sel_shadow = shadow_all[c];
            sel_state  = state_all[c];
            sel_err    = err[c];
         end
      end

      hits = (sel_shadow[IDX_ACC] >= sel_shadow[IDX_MISS]) ?
             (sel_shadow[IDX_ACC] - sel_shadow[IDX_MISS]) : '0;
      // The beat sum is widened before the shift so the byte count cannot overflow.
      bus_bytes = (RD_W'(sel_shadow[IDX_RBEAT]) + RD_W'(sel_shadow[IDX_WBEAT])) << BEAT_SH;

      rd_value = '0;
      if (ch_ok) begin
         case (rd_sel)
            SEL_ACC:       rd_value = RD_W'(sel_shadow[IDX_ACC]);
            SEL_RD:        rd_value = RD_W'(sel_shadow[IDX_RD]);
            SEL_WR:        rd_value = RD_W'(sel_shadow[IDX_WR]);
            SEL_MISS:      rd_value = RD_W'(sel_shadow[IDX_MISS]);
            SEL_WB:        rd_value = RD_W'(sel_shadow[IDX_WB]);
            SEL_RBEAT:     rd_value = RD_W'(sel_shadow[IDX_RBEAT]);
            SEL_WBEAT:     rd_value = RD_W'(sel_shadow[IDX_WBEAT]);
            SEL_HITS:      rd_value = RD_W'(hits);
            SEL_BUS_BYTES: rd_value = bus_bytes;
            SEL_STATUS:    rd_value = RD_W'({sel_err, sel_state});
            default:       rd_value = '0;
         endcase
      end

      rd_data_d  = rd_en ? rd_value : rd_data_q;
      rd_valid_d = rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cache_perf_mon.sv
// Scenario bench for cache_perf_mon: reads are queued with their expected value
// when issued and checked when rd_valid returns.
module tb_cache_perf_mon;

   localparam int CH = 2;
   localparam int CW = 4;
   localparam int BB = 8;
   localparam int TO = 16;
   localparam int RW = CW + 3 + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] req, we, oe, mem_req, mem_wr, mem_rvalid, mem_ready;
   logic          cnt_en, clr, snap, rd_en;
   logic [2:0]    rd_ch;
   logic [3:0]    rd_sel;
   logic [RW-1:0] rd_data;
   logic          rd_valid;
   logic [CH-1:0] err;

   typedef struct {
      logic [RW-1:0] exp;
      string         name;
   } sb_t;

   sb_t sb_q[$];
   sb_t cur;
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;

   cache_perf_mon #(
      .CHANNELS   (CH),
      .CNT_W      (CW),
      .BEAT_BYTES (BB),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .we         (we),
      .oe         (oe),
      .mem_req    (mem_req),
      .mem_wr     (mem_wr),
      .mem_rvalid (mem_rvalid),
      .mem_ready  (mem_ready),
      .cnt_en     (cnt_en),
      .clr        (clr),
      .snap       (snap),
      .rd_en      (rd_en),
      .rd_ch      (rd_ch),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .err        (err)
   );

   // Scoreboard side: every returned read is matched against the oldest issued one.
   always @(posedge clk) begin
      #1;
      if (rd_valid) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rd_valid got rd_data=%0d want no read pending", rd_data);
         end else begin
            cur = sb_q.pop_front();
            if (rd_data !== cur.exp) begin
               bad++;
               $display("FAIL %s got %0d want %0d", cur.name, rd_data, cur.exp);
            end else begin
               $display("read %s = %0d", cur.name, rd_data);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL sim_timeout got no finish want finish");
      $fatal(1, "simulation time limit");
   end

   task automatic read(input int ch, input int sel, input logic [RW-1:0] e_val, input string nm);
      sb_t e;
      @(negedge clk);
      rd_en  = 1'b1;
      rd_ch  = 3'(ch);
      rd_sel = 4'(sel);
      e.exp  = e_val;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic rd_idle();
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic ctrl(input logic s, input logic c);
      @(negedge clk);
      snap = s;
      clr  = c;
      @(negedge clk);
      snap = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic access(input int ch, input logic o, input logic w, input int hold);
      @(negedge clk);
      req[ch] = 1'b1;
      oe[ch]  = o;
      we[ch]  = w;
      repeat (hold - 1) @(negedge clk);
      @(negedge clk);
      req[ch] = 1'b0;
      oe[ch]  = 1'b0;
      we[ch]  = 1'b0;
   endtask

   task automatic burst(input int ch, input logic wr, input int beats);
      @(negedge clk);
      mem_req[ch] = 1'b1;
      mem_wr[ch]  = wr;
      @(negedge clk);
      if (wr) mem_ready[ch] = 1'b1;
      else    mem_rvalid[ch] = 1'b1;
      repeat (beats - 1) @(negedge clk);
      @(negedge clk);
      mem_ready[ch]  = 1'b0;
      mem_rvalid[ch] = 1'b0;
      mem_req[ch]    = 1'b0;
      mem_wr[ch]     = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0; we = '0; oe = '0;
      mem_req = '0; mem_wr = '0; mem_rvalid = '0; mem_ready = '0;
      cnt_en = 1'b1; clr = 1'b0; snap = 1'b0;
      rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
      total++;
      if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
      total++;
      if (err !== '0) begin bad++; $display("FAIL reset_err got %b want 00", err); end
      read(0, 0, 0, "reset_acc");
      read(1, 9, 0, "reset_status");
      rd_idle();
   endtask

   task automatic test_access();
      access(0, 1'b1, 1'b0, 1);
      access(0, 1'b1, 1'b0, 1);
      access(0, 1'b0, 1'b1, 1);
      access(0, 1'b1, 1'b0, 5);
      ctrl(1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid got %b want 0", rd_valid); end
      begin
         sb_t e;
         rd_en = 1'b1; rd_ch = 3'd0; rd_sel = 4'd0;
         e.exp = 4; e.name = "acc";
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      total++;
      if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_latency got rd_valid=%b want 1", rd_valid); end
      @(negedge clk);
      rd_en = 1'b0;
      @(posedge clk); #1;
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse got rd_valid=%b want 0", rd_valid); end
      read(0, 1, 3, "rd");
      read(0, 2, 1, "wr");
      read(2, 0, 0, "ch2_out_of_range");
      read(0, 12, 0, "sel12_reserved");
      read(1, 0, 0, "ch1_acc");
      read(0, 9, 0, "ch0_status_idle");
      rd_idle();
   endtask

   task automatic test_fill_wb();
      ctrl(1'b0, 1'b1);
      burst(1, 1'b0, 4);
      burst(1, 1'b1, 4);
      ctrl(1'b1, 1'b0);
      read(1, 3, 1, "miss");
      read(1, 4, 1, "wb");
      read(1, 5, 4, "rbeat");
      read(1, 6, 4, "wbeat");
      read(1, 8, 64, "bus_bytes");
      read(1, 9, 0, "ch1_status");
      read(0, 0, 0, "ch0_acc_cleared");
      rd_idle();
   endtask

   task automatic test_hits();
      ctrl(1'b0, 1'b1);
      burst(0, 1'b0, 1);
      burst(0, 1'b0, 1);
      ctrl(1'b1, 1'b0);
      read(0, 7, 0, "hits_clamp");
      read(0, 3, 2, "miss_two_fills");
      rd_idle();
      repeat (10) access(0, 1'b0, 1'b0, 1);
      ctrl(1'b1, 1'b0);
      read(0, 0, 10, "acc_ten");
      read(0, 7, 8, "hits_eight");
      rd_idle();
   endtask

   task automatic test_watchdog();
      int cyc;
      ctrl(1'b0, 1'b1);
      @(negedge clk);
      mem_req[0] = 1'b1;
      mem_wr[0]  = 1'b0;
      cyc = 0;
      while (err[0] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (err[0] !== 1'b1 || cyc < TO || cyc > TO + 2) begin
         bad++;
         $display("FAIL watchdog_fire got err=%b after %0d cycles want 1 after %0d..%0d", err[0], cyc, TO, TO + 2);
      end
      total++;
      if (err[1] !== 1'b0) begin bad++; $display("FAIL watchdog_other_ch got %b want 0", err[1]); end
      read(0, 9, 4, "status_err_idle");
      rd_idle();
      mem_rvalid[0] = 1'b1;
      @(negedge clk);
      mem_rvalid[0] = 1'b0;
      mem_req[0]    = 1'b0;
      @(negedge clk);
      ctrl(1'b1, 1'b0);
      read(0, 3, 0, "miss_after_timeout");
      read(0, 5, 1, "rbeat_after_timeout");
      rd_idle();
      total++;
      if (err[0] !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err[0]); end
      ctrl(1'b0, 1'b1);
      total++;
      if (err !== '0) begin bad++; $display("FAIL err_clr got %b want 00", err); end
      read(0, 9, 0, "status_after_clr");
      rd_idle();
   endtask

   task automatic test_saturation();
      ctrl(1'b0, 1'b1);
      @(negedge clk);
      mem_rvalid[1] = 1'b1;
      repeat (20) @(negedge clk);
      mem_rvalid[1] = 1'b0;
      ctrl(1'b1, 1'b1);
      read(1, 5, 15, "rbeat_saturated");
      read(1, 8, 120, "bus_bytes_saturated");
      read(1, 3, 0, "miss_beats_only");
      rd_idle();
      @(negedge clk);
      mem_rvalid[1] = 1'b1;
      @(negedge clk);
      mem_rvalid[1] = 1'b0;
      ctrl(1'b1, 1'b0);
      read(1, 5, 1, "rbeat_after_snap_clr");
      rd_idle();
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      mem_req[0] = 1'b1;
      mem_wr[0]  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      read(0, 9, 0, "status_after_mid_reset");
      rd_idle();
      mem_rvalid[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_rvalid[0] = 1'b0;
      mem_req[0]    = 1'b0;
      @(negedge clk);
      burst(0, 1'b0, 2);
      ctrl(1'b1, 1'b0);
      read(0, 3, 1, "miss_clean_burst");
      read(0, 5, 4, "rbeat_total");
      rd_idle();
   endtask

   task automatic test_cnt_en();
      ctrl(1'b0, 1'b1);
      cnt_en = 1'b0;
      @(negedge clk);
      mem_req[0] = 1'b1;
      mem_wr[0]  = 1'b0;
      read(0, 9, 1, "status_load_frozen");
      rd_idle();
      mem_rvalid[0] = 1'b1;
      repeat (3) @(negedge clk);
      mem_rvalid[0] = 1'b0;
      mem_req[0]    = 1'b0;
      @(negedge clk);
      read(0, 9, 0, "status_idle_frozen");
      rd_idle();
      cnt_en = 1'b1;
      ctrl(1'b1, 1'b0);
      read(0, 3, 0, "miss_frozen");
      read(0, 5, 0, "rbeat_frozen");
      rd_idle();
   endtask

   initial begin
      test_reset();
      test_access();
      test_fill_wb();
      test_hits();
      test_watchdog();
      test_saturation();
      test_reset_mid_burst();
      test_cnt_en();
      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL reads_outstanding got %0d want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
